// File: rtl/chanels_scheduler.sv
// chanels_scheduler: round-robin arbiter that issues per-channel (ac, ph) samples to the distributor, one frame of 2^STADIES per channel.
module chanels_scheduler #(
  parameter int WIDTH   = 32,
  parameter int CHANELS = 4,
  parameter int STADIES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [CHANELS-1:0]           s_vld,
  output logic [CHANELS-1:0]           s_rdy,
  input  logic [CHANELS*WIDTH-1:0]     s_ac,
  input  logic [CHANELS*WIDTH-1:0]     s_ph,
  output logic                         o_vld,
  output logic [$clog2(CHANELS)-1:0]   o_addres,
  output logic [WIDTH-1:0]             o_ac,
  output logic [WIDTH-1:0]             o_ph,
  output logic                         o_busy,
  output logic                         o_frame_done
);
  localparam int A = $clog2(CHANELS);
  localparam logic [STADIES:0] N = {1'b1, {STADIES{1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state;
  logic [WIDTH-1:0]   r_ac [CHANELS];
  logic [WIDTH-1:0]   r_ph [CHANELS];
  logic [CHANELS-1:0] r_hv;
  logic [STADIES:0]   r_acc [CHANELS];
  logic [STADIES:0]   r_iss [CHANELS];
  logic [A-1:0]       r_ptr;
  logic [CHANELS-1:0] w_grant;
  logic [A-1:0]       w_g;
  logic [A-1:0]       w_idx;
  logic               w_any;
  logic               w_last;
  logic               w_clr;
  assign o_busy       = r_state != IDLE;
  assign o_frame_done = r_state == DONE;
  assign w_clr        = r_state == IDLE && i_start;
  // Rotating priority search starting at the pointer; w_last flags the grant that completes the frame.
  always_comb begin
    w_any   = 1'b0;
    w_g     = '0;
    w_idx   = '0;
    for (int i = 0; i < CHANELS; i++) begin
      w_idx = r_ptr + A'(i);
      if (!w_any && r_hv[w_idx] && r_state == RUN) begin
        w_any = 1'b1;
        w_g   = w_idx;
      end
    end
    w_grant = w_any ? (CHANELS'(1) << w_g) : '0;
    w_last  = w_any;
    s_rdy   = '0;
    for (int c = 0; c < CHANELS; c++) begin
      w_last   = w_last & ((r_iss[c] + {{STADIES{1'b0}}, w_grant[c]}) == N);
      s_rdy[c] = r_state == RUN && r_acc[c] < N && (!r_hv[c] || w_grant[c]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_hv     <= '0;
      r_ptr    <= '0;
      o_vld    <= 1'b0;
      o_addres <= '0;
      o_ac     <= '0;
      o_ph     <= '0;
      for (int c = 0; c < CHANELS; c++) begin
        r_acc[c] <= '0;
        r_iss[c] <= '0;
        r_ac[c]  <= '0;
        r_ph[c]  <= '0;
      end
    end else begin
      o_vld <= w_any;
      if (w_any) begin
        o_addres <= w_g;
        o_ac     <= r_ac[w_g];
        o_ph     <= r_ph[w_g];
        r_ptr    <= w_g + 1'b1;
      end
      if (w_clr) r_ptr <= '0;
      for (int c = 0; c < CHANELS; c++) begin
        if (w_grant[c]) begin
          r_hv[c]  <= 1'b0;
          r_iss[c] <= r_iss[c] + 1'b1;
        end
        if (s_vld[c] && s_rdy[c]) begin
          r_hv[c]  <= 1'b1;
          r_ac[c]  <= s_ac[c*WIDTH +: WIDTH];
          r_ph[c]  <= s_ph[c*WIDTH +: WIDTH];
          r_acc[c] <= r_acc[c] + 1'b1;
        end
        if (w_clr) begin
          r_acc[c] <= '0;
          r_iss[c] <= '0;
        end
      end
      r_state <= r_state == IDLE ? (i_start ? RUN : IDLE) :
                 r_state == DONE ? IDLE : (w_last ? DONE : RUN);
    end
  end
endmodule

// File: tb/tb_chanels_scheduler.sv
// tb_chanels_scheduler: directed scenarios for the round-robin channel scheduler (CHANELS=4, STADIES=2).
module tb_chanels_scheduler;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [3:0]   s_vld = '0;
  logic [3:0]   s_rdy;
  logic [127:0] s_ac = '0;
  logic [127:0] s_ph = '0;
  logic         o_vld;
  logic [1:0]   o_addres;
  logic [31:0]  o_ac;
  logic [31:0]  o_ph;
  logic         o_busy;
  logic         o_frame_done;
  int           n_chk = 0;
  int           n_fail = 0;
  int           idx [4];
  logic [31:0]  ac_base = '0;
  logic [31:0]  ph_base = '0;

  always #5 clk = ~clk;

  chanels_scheduler #(.WIDTH(32), .CHANELS(4), .STADIES(2)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .s_vld(s_vld), .s_rdy(s_rdy),
    .s_ac(s_ac), .s_ph(s_ph), .o_vld(o_vld), .o_addres(o_addres), .o_ac(o_ac),
    .o_ph(o_ph), .o_busy(o_busy), .o_frame_done(o_frame_done));

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      s_ac[c*32 +: 32] = ac_base + 32'(idx[c]);
      s_ph[c*32 +: 32] = ph_base - 32'(idx[c]);
    end
  endtask

  // Source model: each channel advances its sample index on a handshake.
  task automatic tick();
    logic [3:0] x;
    @(negedge clk);
    x = s_vld & s_rdy;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) if (x[c]) idx[c]++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_start = 1'b0;
    s_vld = '0;
    for (int c = 0; c < 4; c++) idx[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic setup_full();
    ac_base = 32'd2;
    ph_base = 32'd2;
    s_vld = 4'b1111;
    for (int c = 0; c < 4; c++) idx[c] = 0;
    drive();
  endtask

  // Expects the full-load frame from its first beat: addr j%4, ac 2+j/4, ph 2-j/4.
  task automatic run_frame(input bit mid_start, input string tag);
    int  beats = 0;
    bit  done = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (mid_start) i_start = (cyc == 6);
      tick();
      if (beats > 0 && beats < 16) begin
        n_chk++;
        if (o_vld !== 1'b1) begin n_fail++; $display("FAIL %s contig beat %0d: o_vld=%b want 1", tag, beats, o_vld); end
      end
      if (o_vld) begin
        n_chk += 4;
        if (o_addres !== 2'(beats % 4)) begin n_fail++; $display("FAIL %s addr beat %0d: got %0d want %0d", tag, beats, o_addres, beats % 4); end
        if (o_ac !== 32'(2 + beats / 4)) begin n_fail++; $display("FAIL %s ac beat %0d: got %0h want %0h", tag, beats, o_ac, 32'(2 + beats / 4)); end
        if (o_ph !== 32'(2 - beats / 4)) begin n_fail++; $display("FAIL %s ph beat %0d: got %0h want %0h", tag, beats, o_ph, 32'(2 - beats / 4)); end
        if (o_frame_done !== (beats == 15)) begin n_fail++; $display("FAIL %s frame_done beat %0d: got %b want %b", tag, beats, o_frame_done, beats == 15); end
        beats++;
      end else begin
        n_chk++;
        if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL %s frame_done without beat: got %b want 0", tag, o_frame_done); end
      end
      if (o_frame_done) done = 1;
    end
    i_start = 1'b0;
    n_chk++;
    if (beats != 16) begin n_fail++; $display("FAIL %s beat count: got %0d want 16", tag, beats); end
    tick();
    n_chk += 2;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy after done: got %b want 0", tag, o_busy); end
    if (o_vld !== 1'b0) begin n_fail++; $display("FAIL %s vld after done: got %b want 0", tag, o_vld); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk += 7;
    if (o_vld !== 1'b0) begin n_fail++; $display("FAIL reset o_vld: got %b want 0", o_vld); end
    if (o_addres !== 2'd0) begin n_fail++; $display("FAIL reset o_addres: got %0d want 0", o_addres); end
    if (o_ac !== 32'd0) begin n_fail++; $display("FAIL reset o_ac: got %0h want 0", o_ac); end
    if (o_ph !== 32'd0) begin n_fail++; $display("FAIL reset o_ph: got %0h want 0", o_ph); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset o_busy: got %b want 0", o_busy); end
    if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset o_frame_done: got %b want 0", o_frame_done); end
    if (s_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset s_rdy: got %b want 0000", s_rdy); end
    rst = 1'b0;
    tick();
    n_chk++;
    if (s_rdy !== 4'b0000) begin n_fail++; $display("FAIL idle s_rdy: got %b want 0000", s_rdy); end
    start();
    n_chk += 3;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL start o_busy: got %b want 1", o_busy); end
    if (s_rdy !== 4'b1111) begin n_fail++; $display("FAIL start s_rdy: got %b want 1111", s_rdy); end
    if (o_vld !== 1'b0) begin n_fail++; $display("FAIL start o_vld: got %b want 0", o_vld); end
  endtask

  task automatic test_full_load();
    do_reset();
    setup_full();
    start();
    run_frame(1'b0, "full");
  endtask

  task automatic test_single_channel();
    int beats = 0;
    do_reset();
    ac_base = 32'd10;
    ph_base = 32'd0;
    s_vld = 4'b0100;
    drive();
    start();
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      n_chk++;
      if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL single frame_done: got %b want 0", o_frame_done); end
      if (o_vld) begin
        n_chk += 2;
        if (o_addres !== 2'd2) begin n_fail++; $display("FAIL single addr beat %0d: got %0d want 2", beats, o_addres); end
        if (o_ac !== 32'(10 + beats)) begin n_fail++; $display("FAIL single ac beat %0d: got %0d want %0d", beats, o_ac, 10 + beats); end
        beats++;
      end
    end
    n_chk += 3;
    if (beats != 4) begin n_fail++; $display("FAIL single beat count: got %0d want 4", beats); end
    if (s_rdy[2] !== 1'b0) begin n_fail++; $display("FAIL single s_rdy[2]: got %b want 0", s_rdy[2]); end
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL single o_busy: got %b want 1", o_busy); end
  endtask

  task automatic test_fairness();
    int beats = 0;
    do_reset();
    ac_base = 32'd0;
    ph_base = 32'd0;
    s_vld = 4'b1001;
    drive();
    start();
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      n_chk++;
      if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL fair frame_done: got %b want 0", o_frame_done); end
      if (o_vld) begin
        n_chk += 2;
        if (o_addres !== ((beats % 2) ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL fair addr beat %0d: got %0d want %0d", beats, o_addres, (beats % 2) ? 3 : 0); end
        if (o_ac !== 32'(beats / 2)) begin n_fail++; $display("FAIL fair ac beat %0d: got %0d want %0d", beats, o_ac, beats / 2); end
        beats++;
      end
    end
    n_chk += 2;
    if (beats != 8) begin n_fail++; $display("FAIL fair beat count: got %0d want 8", beats); end
    if ({s_rdy[3], s_rdy[0]} !== 2'b00) begin n_fail++; $display("FAIL fair s_rdy: got %b want 0xx0", s_rdy); end
  endtask

  task automatic test_abort();
    int beats = 0;
    do_reset();
    setup_full();
    start();
    for (int cyc = 0; cyc < 30 && beats < 5; cyc++) begin
      tick();
      if (o_vld) beats++;
    end
    n_chk++;
    if (beats != 5) begin n_fail++; $display("FAIL abort pre-beats: got %0d want 5", beats); end
    rst = 1'b1;
    #1;
    n_chk += 4;
    if (o_vld !== 1'b0) begin n_fail++; $display("FAIL abort o_vld: got %b want 0", o_vld); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort o_busy: got %b want 0", o_busy); end
    if (s_rdy !== 4'b0000) begin n_fail++; $display("FAIL abort s_rdy: got %b want 0000", s_rdy); end
    if (o_ac !== 32'd0) begin n_fail++; $display("FAIL abort o_ac: got %0h want 0", o_ac); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    setup_full();
    start();
    run_frame(1'b0, "abort");
  endtask

  task automatic test_ignored_start();
    do_reset();
    setup_full();
    start();
    run_frame(1'b1, "midstart");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_single_channel();
    test_fairness();
    test_abort();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
